// File: rtl/load_unit_ctrl.sv
// Load unit controller.
// Takes a load request from execute, issues a word-aligned read to data
// memory over a req/ack handshake, then extracts and extends the addressed
// byte, half or word into a registered result for the writeback mux.
// Misaligned or illegal-size requests and memory timeouts are each flagged
// with a one-cycle pulse.
module load_unit_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        load_req_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic [31:0] addr_in,
  output logic        dmem_req_out,
  output logic [31:0] dmem_addr_out,
  input  logic        dmem_ack_in,
  input  logic [31:0] dmem_rdata_in,
  output logic [31:0] lu_output_out,
  output logic        lu_valid_out,
  output logic        stall_out,
  output logic        misaligned_out,
  output logic        timeout_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr;
  logic [1:0]       r_size;
  logic             r_unsigned;
  logic [31:0]      r_lu;
  logic             r_timeout;

  logic             w_can_accept;
  logic             w_misaligned;
  logic             w_accept;
  logic             w_trap;
  logic             w_limit;
  logic             w_ack_hit;
  logic             w_timeout_hit;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_extracted;

  // Request qualification: DONE accepts new requests exactly like IDLE.
  always_comb begin
    w_can_accept = (r_state == S_IDLE) || (r_state == S_DONE);
    unique case (load_size_in)
      SZ_BYTE: w_misaligned = 1'b0;
      SZ_HALF: w_misaligned = addr_in[0];
      SZ_WORD: w_misaligned = (addr_in[1:0] != 2'b00);
      default: w_misaligned = 1'b1;
    endcase
    w_accept      = w_can_accept && load_req_in && !w_misaligned;
    w_trap        = w_can_accept && load_req_in &&  w_misaligned;
    w_limit       = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    // An ack on the limit cycle wins over the timeout.
    w_ack_hit     = (r_state == S_WAIT) && dmem_ack_in;
    w_timeout_hit = (r_state == S_WAIT) && !dmem_ack_in && w_limit;
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept)    w_next = S_WAIT;
        else if (w_trap) w_next = S_ERR;
        else             w_next = S_IDLE;
      end
      S_WAIT: begin
        if (w_ack_hit)          w_next = S_DONE;
        else if (w_timeout_hit) w_next = S_IDLE;
        else                    w_next = S_WAIT;
      end
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register; reset aborts any outstanding access.
  always_ff @(posedge clk_in) begin
    // NOTE: state uses non-blocking assignments and a synchronous reset sampled at the clock edge.
    if (!rst_in) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Byte/half selection from the latched address, then sign or zero extension.
  always_comb begin
    unique case (r_addr[1:0])
      2'd0:    w_byte = dmem_rdata_in[7:0];
      2'd1:    w_byte = dmem_rdata_in[15:8];
      2'd2:    w_byte = dmem_rdata_in[23:16];
      default: w_byte = dmem_rdata_in[31:24];
    endcase
    w_half = r_addr[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];
    unique case (r_size)
      SZ_BYTE: w_extracted = {{24{w_byte[7]  && !r_unsigned}}, w_byte};
      SZ_HALF: w_extracted = {{16{w_half[15] && !r_unsigned}}, w_half};
      default: w_extracted = dmem_rdata_in;
    endcase
  end

  // Latched request fields, timeout counter, result and timeout pulse.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_addr     <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_cnt      <= '0;
      r_lu       <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr     <= addr_in;
        r_size     <= load_size_in;
        r_unsigned <= load_unsigned_in;
        r_cnt      <= '0;
      end else if ((r_state == S_WAIT) && !dmem_ack_in && !w_limit) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_ack_hit)          r_lu <= w_extracted;
      else if (w_timeout_hit) r_lu <= '0;

      r_timeout <= w_timeout_hit;
    end
  end

  assign dmem_req_out   = (r_state == S_WAIT);
  assign dmem_addr_out  = {r_addr[31:2], 2'b00};
  assign lu_output_out  = r_lu;
  assign lu_valid_out   = (r_state == S_DONE);
  assign misaligned_out = (r_state == S_ERR);
  assign timeout_out    = r_timeout;
  // Misaligned requests do not stall; the trap path handles them.
  assign stall_out      = (r_state == S_WAIT) || w_accept;

endmodule

// File: tb/tb_load_unit_ctrl.sv
// Self-checking bench for load_unit_ctrl: directed scenarios followed by
// randomized loads, compared against a transaction-level reference model.
module tb_load_unit_ctrl;

  localparam int unsigned TO = 8;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        load_req_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in;
  logic [31:0] addr_in;
  logic        dmem_req_out;
  logic [31:0] dmem_addr_out;
  logic        dmem_ack_in;
  logic [31:0] dmem_rdata_in;
  logic [31:0] lu_output_out;
  logic        lu_valid_out;
  logic        stall_out;
  logic        misaligned_out;
  logic        timeout_out;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_lu = '0;

  load_unit_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .load_req_in     (load_req_in),
    .load_size_in    (load_size_in),
    .load_unsigned_in(load_unsigned_in),
    .addr_in         (addr_in),
    .dmem_req_out    (dmem_req_out),
    .dmem_addr_out   (dmem_addr_out),
    .dmem_ack_in     (dmem_ack_in),
    .dmem_rdata_in   (dmem_rdata_in),
    .lu_output_out   (lu_output_out),
    .lu_valid_out    (lu_valid_out),
    .stall_out       (stall_out),
    .misaligned_out  (misaligned_out),
    .timeout_out     (timeout_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: which requests the unit accepts.
  function automatic bit ref_aligned(input logic [31:0] a, input logic [1:0] sz);
    int unsigned off = a % 4;
    case (sz)
      2'd0:    return 1'b1;
      2'd1:    return (off % 2) == 0;
      2'd2:    return off == 0;
      default: return 1'b0;
    endcase
  endfunction

  // Reference: value delivered to writeback, by shifting and masking.
  function automatic logic [31:0] ref_value(input logic [31:0] rdata, input logic [31:0] a,
                                            input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    int unsigned off = a % 4;
    if (sz == 2'd0) begin
      v = (rdata >> (8 * off)) & 32'h0000_00FF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rdata >> ((off >= 2) ? 16 : 0)) & 32'h0000_FFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  // One load, entered and left at 1 time unit after a rising edge.
  // ack_delay = number of WAIT cycles before ack; >= TO means never acked.
  task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                          input int ack_delay, input logic [31:0] rdata);
    bit ok = ref_aligned(a, sz);
    bit done = 1'b0;
    load_req_in      = 1'b1;
    load_size_in     = sz;
    load_unsigned_in = uns;
    addr_in          = a;
    #1;
    check("stall_on_request", stall_out, ok);
    @(posedge clk_in); #1;
    load_req_in = 1'b0;
    addr_in     = $urandom;
    if (!ok) begin
      check("misaligned_pulse", misaligned_out, 1'b1);
      check("misaligned_no_req", dmem_req_out, 1'b0);
      check("misaligned_lu_kept", lu_output_out, exp_lu);
      #1;
      check("misaligned_no_stall", stall_out, 1'b0);
      @(posedge clk_in); #1;
      check("misaligned_one_cycle", misaligned_out, 1'b0);
      check("misaligned_still_no_req", dmem_req_out, 1'b0);
      return;
    end
    for (int k = 0; k < int'(TO) && !done; k++) begin
      check("wait_req", dmem_req_out, 1'b1);
      check("wait_addr", dmem_addr_out, a & 32'hFFFF_FFFC);
      check("wait_no_valid", lu_valid_out, 1'b0);
      check("wait_no_timeout", timeout_out, 1'b0);
      if (k == ack_delay) begin
        dmem_ack_in   = 1'b1;
        dmem_rdata_in = rdata;
      end
      #1;
      check("wait_stall", stall_out, 1'b1);
      @(posedge clk_in); #1;
      if (dmem_ack_in) begin
        exp_lu = ref_value(rdata, a, sz, uns);
        check("result_valid", lu_valid_out, 1'b1);
        check("result_value", lu_output_out, exp_lu);
        check("result_req_dropped", dmem_req_out, 1'b0);
        check("result_no_timeout", timeout_out, 1'b0);
        done = 1'b1;
      end
      dmem_ack_in   = 1'b0;
      dmem_rdata_in = $urandom;
    end
    if (!done) begin
      exp_lu = '0;
      check("timeout_pulse", timeout_out, 1'b1);
      check("timeout_lu_zero", lu_output_out, exp_lu);
      check("timeout_req_dropped", dmem_req_out, 1'b0);
      check("timeout_no_valid", lu_valid_out, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    load_req_in = 1'b0;
    repeat (n) begin
      @(posedge clk_in); #1;
      check("idle_no_req", dmem_req_out, 1'b0);
      check("idle_no_valid", lu_valid_out, 1'b0);
      check("idle_no_misaligned", misaligned_out, 1'b0);
      check("idle_no_timeout", timeout_out, 1'b0);
      check("idle_no_stall", stall_out, 1'b0);
      check("idle_lu_held", lu_output_out, exp_lu);
    end
  endtask

  initial begin
    rst_in           = 1'b0;
    load_req_in      = 1'b0;
    load_size_in     = 2'b00;
    load_unsigned_in = 1'b0;
    addr_in          = '0;
    dmem_ack_in      = 1'b0;
    dmem_rdata_in    = '0;
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_req", dmem_req_out, 1'b0);
    check("reset_addr", dmem_addr_out, 32'h0);
    check("reset_lu", lu_output_out, 32'h0);
    check("reset_valid", lu_valid_out, 1'b0);
    check("reset_stall", stall_out, 1'b0);
    check("reset_misaligned", misaligned_out, 1'b0);
    check("reset_timeout", timeout_out, 1'b0);
    rst_in = 1'b1;
    idle(1);

    // Signed byte, acked on the first WAIT cycle.
    run_load(32'h0000_0103, 2'b00, 1'b0, 0, 32'h80FF_1234);
    check("lb_value_const", lu_output_out, 32'hFFFF_FF80);
    idle(1);

    // Unsigned half, ack after five WAIT cycles (six cycles of request).
    run_load(32'h0000_0202, 2'b01, 1'b1, 5, 32'h8001_7FFF);
    check("lhu_value_const", lu_output_out, 32'h0000_8001);
    idle(1);

    // Misaligned word: trap pulse, result retained.
    run_load(32'h0000_0301, 2'b10, 1'b0, 0, 32'h0);
    check("lw_misaligned_kept", lu_output_out, 32'h0000_8001);
    idle(1);

    // Illegal size.
    run_load(32'h0000_0300, 2'b11, 1'b0, 0, 32'h0);
    idle(1);

    // Timeout with no ack, then ack exactly on the limit cycle.
    run_load(32'h0000_0500, 2'b10, 1'b0, TO, 32'h0);
    idle(1);
    run_load(32'h0000_0504, 2'b10, 1'b0, TO - 1, 32'hCAFE_F00D);
    check("limit_ack_value", lu_output_out, 32'hCAFE_F00D);
    idle(1);

    // Back-to-back: second request presented during DONE.
    run_load(32'h0000_0400, 2'b10, 1'b0, 0, 32'h1357_9BDF);
    check("b2b_word", lu_output_out, 32'h1357_9BDF);
    run_load(32'h0000_0406, 2'b01, 1'b0, 1, 32'h9ABC_1234);
    check("b2b_half", lu_output_out, 32'hFFFF_9ABC);
    idle(1);

    // Reset during WAIT; the late ack must be ignored.
    load_req_in  = 1'b1;
    load_size_in = 2'b10;
    addr_in      = 32'h0000_0600;
    @(posedge clk_in); #1;
    load_req_in = 1'b0;
    check("rst_wait_req", dmem_req_out, 1'b1);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    exp_lu = '0;
    check("rst_mid_req", dmem_req_out, 1'b0);
    check("rst_mid_addr", dmem_addr_out, 32'h0);
    check("rst_mid_lu", lu_output_out, 32'h0);
    check("rst_mid_valid", lu_valid_out, 1'b0);
    check("rst_mid_stall", stall_out, 1'b0);
    dmem_ack_in   = 1'b1;
    dmem_rdata_in = 32'hDEAD_BEEF;
    @(posedge clk_in); #1;
    dmem_ack_in = 1'b0;
    check("late_ack_no_valid", lu_valid_out, 1'b0);
    check("late_ack_lu", lu_output_out, 32'h0);
    check("late_ack_no_req", dmem_req_out, 1'b0);
    idle(1);

    // Randomized loads against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra = $urandom;
      logic [1:0]  rs = 2'($urandom_range(0, 3));
      run_load(ra, rs, 1'($urandom_range(0, 1)), int'($urandom_range(0, TO)), $urandom);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
